// File: rtl/gf163_mul_sched_if.sv
// Handshake and operand/result bundle for the GF(2^163) scheduled multiplier.
interface gf163_mul_sched_if;
  logic         start;
  logic [162:0] a;
  logic [162:0] b;
  logic         busy;
  logic         done;
  logic [162:0] c;

  modport master (output start, output a, output b, input busy, input done, input c);
  modport slave  (input start, input a, input b, output busy, output done, output c);
endinterface

// File: rtl/gf163_mul_sched.sv
// GF(2^163) multiplier, f(x)=x^163+x^7+x^6+x^3+1, time-sharing one 11x11 Karatsuba core over 15x15 digits.
// Define GF163_ZSKIP_EN to skip rows whose A digit is zero.
module karatsuba11 (
  input  logic [10:0] i_x,
  input  logic [10:0] i_y,
  output logic [20:0] o_p
);
  function automatic logic [10:0] clmul6(input logic [5:0] x, input logic [5:0] y);
    logic [10:0] acc;
    acc = '0;
    for (int unsigned k = 0; k < 6; k++)
      if (y[k]) acc = acc ^ ({5'b0, x} << k);
    return acc;
  endfunction

  logic [5:0]  w_x0, w_x1, w_y0, w_y1;
  logic [10:0] w_p0, w_p2, w_pm, w_mid;

  assign w_x0  = i_x[5:0];
  assign w_x1  = {1'b0, i_x[10:6]};
  assign w_y0  = i_y[5:0];
  assign w_y1  = {1'b0, i_y[10:6]};
  assign w_p0  = clmul6(w_x0, w_y0);
  assign w_p2  = clmul6(w_x1, w_y1);
  assign w_pm  = clmul6(w_x0 ^ w_x1, w_y0 ^ w_y1);
  assign w_mid = w_pm ^ w_p0 ^ w_p2;
  assign o_p   = {10'b0, w_p0} ^ {4'b0, w_mid, 6'b0} ^ 21'({w_p2, 12'b0});
endmodule

module gf163_mul_sched (
  input  logic             clk,
  input  logic             rst,
  gf163_mul_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, RED, DONE} state_t;

  state_t       r_state, w_next;
  logic [164:0] r_a, r_b;
  logic [328:0] r_acc;
  logic [3:0]   r_i, r_j;
  logic [162:0] r_c;

  logic [10:0]  w_ai, w_bj;
  logic [20:0]  w_prod;
  logic [8:0]   w_off;
  logic         w_row_skip, w_row_end, w_last;
  logic         w_busy, w_done;

  logic [165:0] w_hi;
  logic [172:0] w_f1;
  logic [9:0]   w_hi2;
  logic [162:0] w_red;

  assign w_ai  = r_a[11*r_i +: 11];
  assign w_bj  = r_b[11*r_j +: 11];
  assign w_off = 9'(11 * (32'(r_i) + 32'(r_j)));

  karatsuba11 u_kara (
    .i_x (w_ai),
    .i_y (w_bj),
    .o_p (w_prod)
  );

`ifdef GF163_ZSKIP_EN
  assign w_row_skip = (r_j == 4'd0) && (w_ai == '0);
`else
  assign w_row_skip = 1'b0;
`endif
  assign w_row_end = (r_j == 4'd14) || w_row_skip;
  assign w_last    = w_row_end && (r_i == 4'd14);

  // Two folds of x^163 = x^7+x^6+x^3+1: the first leaves at most 10 excess bits, the second none.
  assign w_hi  = r_acc[328:163];
  assign w_f1  = {10'b0, r_acc[162:0]} ^ {7'b0, w_hi} ^ {4'b0, w_hi, 3'b0}
               ^ {1'b0, w_hi, 6'b0} ^ {w_hi, 7'b0};
  assign w_hi2 = w_f1[172:163];
  assign w_red = w_f1[162:0] ^ {153'b0, w_hi2} ^ {150'b0, w_hi2, 3'b0}
               ^ {147'b0, w_hi2, 6'b0} ^ {146'b0, w_hi2, 7'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: if (bus.start) w_next = MUL;
      MUL: begin
        w_busy = 1'b1;
        if (w_last) w_next = RED;
      end
      RED: begin
        w_busy = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_i   <= '0;
      r_j   <= '0;
      r_c   <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_a   <= {2'b0, bus.a};
          r_b   <= {2'b0, bus.b};
          r_acc <= '0;
          r_i   <= '0;
          r_j   <= '0;
        end
        MUL: begin
          r_acc[w_off +: 21] <= r_acc[w_off +: 21] ^ w_prod;
          if (w_last) begin
            r_i <= '0;
            r_j <= '0;
          end else if (w_row_end) begin
            r_i <= r_i + 4'd1;
            r_j <= '0;
          end else begin
            r_j <= r_j + 4'd1;
          end
        end
        RED: r_c <= w_red;
        default: ;
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.c    = r_c;
endmodule

// File: tb/tb_gf163_mul_sched.sv
// Scoreboard bench for gf163_mul_sched: stimulus pushes expected results, a negedge monitor checks each done pulse.
module tb_gf163_mul_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gf163_mul_sched_if bus ();

  gf163_mul_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [162:0] c;
    int unsigned  t;
    int unsigned  blen;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc = 0;
  int unsigned run = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [162:0] act, input logic [162:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic logic [162:0] gf_ref(input logic [162:0] x, input logic [162:0] y);
    logic [162:0] r;
    logic         cy;
    r = '0;
    for (int i = 162; i >= 0; i--) begin
      cy = r[162];
      r  = r << 1;
      if (cy) r = r ^ 163'hC9;
      if (y[i]) r = r ^ x;
    end
    return r;
  endfunction

  function automatic int unsigned mul_len(input logic [162:0] av);
    logic [164:0] ax;
    int unsigned  n;
    ax = {2'b0, av};
    n  = 0;
    for (int d = 0; d < 15; d++)
      if (ax[11*d +: 11] != 11'd0) n++;
`ifdef GF163_ZSKIP_EN
    return 15*n + (15 - n);
`else
    return (n > 100) ? 0 : 225;
`endif
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) run = 0;
    else begin
      if (bus.busy) run++;
      if (bus.done) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          e = sbq.pop_front();
          check("c", bus.c, e.c);
          check("done_cycle", 163'(cyc), 163'(e.t));
          check("busy_len", 163'(run), 163'(e.blen));
        end
        run = 0;
      end
    end
  end

  task automatic push_exp(input logic [162:0] av, input logic [162:0] cv, input int unsigned k);
    exp_t e;
    int unsigned ml;
    ml     = mul_len(av);
    e.c    = cv;
    e.t    = k + ml + 1;
    e.blen = ml + 1;
    sbq.push_back(e);
  endtask

  task automatic wait_idle();
    int unsigned cnt;
    cnt = 0;
    while ((bus.busy || bus.done) && cnt < 2000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    if (cnt >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got busy after %0d cycles expected idle", cnt);
    end
  endtask

  task automatic issue(input logic [162:0] av, input logic [162:0] bv, input bit track,
                       input logic [162:0] cv, output int unsigned k);
    wait_idle();
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    k         = cyc;
    bus.start = 1'b0;
    if (track) push_exp(av, cv, k);
  endtask

  initial begin
    int unsigned  k, p, inj;
    logic [162:0] ones, oa[3], ob[3], oc[3];
    ones      = '1;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 163'(bus.busy), 163'(0));
    check("reset_done", 163'(bus.done), 163'(0));
    check("reset_c", bus.c, 163'(0));
    @(negedge clk);
    rst = 1'b0;

    issue(163'h1, 163'h1, 1'b1, 163'h1, k);
    issue(163'h1 << 162, 163'h2, 1'b1, 163'hC9, k);
    issue(ones, ones, 1'b1, gf_ref(ones, ones), k);
    issue(163'h1 << 161, 163'h8, 1'b1, 163'h192, k);
    issue(163'h1, 163'h1 << 100, 1'b1, 163'h1 << 100, k);
    issue(163'h0, 163'h1 << 100, 1'b1, 163'h0, k);

    // Restart attempt with different operands mid-operation must be ignored.
    issue((163'h1 << 162) | 163'h1, 163'h4, 1'b1, 163'h196, k);
    inj = (mul_len((163'h1 << 162) | 163'h1) > 60) ? 50 : 10;
    repeat (inj) @(posedge clk);
    #1;
    bus.a     = 163'h7;
    bus.b     = 163'h9;
    bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b0;

    issue(ones, 163'h5, 1'b0, 163'h0, k);
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_busy", 163'(bus.busy), 163'(0));
    check("rst_done", 163'(bus.done), 163'(0));
    check("rst_c", bus.c, 163'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(163'h3, 163'h5, 1'b1, 163'hF, k);

    oa[0] = ones;            ob[0] = ones;  oc[0] = gf_ref(ones, ones);
    oa[1] = 163'h1 << 161;   ob[1] = 163'h8; oc[1] = 163'h192;
    oa[2] = 163'h3;          ob[2] = 163'h5; oc[2] = 163'hF;
    wait_idle();
    bus.a     = oa[0];
    bus.b     = ob[0];
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    push_exp(oa[0], oc[0], k);
    for (int idx = 1; idx < 3; idx++) begin
      p = mul_len(oa[idx-1]) + 3;
      repeat (10) @(posedge clk);
      #1;
      bus.a = oa[idx];
      bus.b = ob[idx];
      repeat (p - 10) @(posedge clk);
      #1;
      k = k + p;
      push_exp(oa[idx], oc[idx], k);
    end
    bus.start = 1'b0;

    for (int w = 0; w < 2000 && sbq.size() != 0; w++) @(posedge clk);
    repeat (3) @(posedge clk);
    while (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_done: got none expected done at cycle %0d", e.t);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gf163_mul_sched.md
GF163_MUL_SCHED -- requirements
Module: gf163_mul_sched

Interface
REQ-001 The block SHALL have these parameters: none; all widths are fixed by GF(2^163).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a multiplication; sampled only in IDLE.
REQ-005 a  input  163  operand A in polynomial basis, bit k = coefficient of x^k.
REQ-006 b  input  163  operand B in the same basis.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 done  output  1  one-cycle pulse; c is valid while done is high.
REQ-009 c  output  163  registered result, A*B mod f(x), with f(x) = x^163+x^7+x^6+x^3+1.

Function
REQ-010 The block SHALL compute the product using one instance of the existing karatsuba11 core (11x11 -> 21-bit carry-less product), time-shared across all digit products.
REQ-011 Operands SHALL be zero-extended to 165 bits and split into 15 digits of 11 bits, a_i = A[11i+10:11i] and b_j likewise, for i,j = 0..14.
REQ-012 The FSM SHALL have states IDLE, MUL, RED and DONE; the reset state is IDLE.
REQ-013 In IDLE with start=1, the block SHALL capture a and b, clear the 329-bit accumulator, set i=j=0, and enter MUL on that edge.
REQ-014 In MUL, each cycle SHALL XOR the 21-bit product a_i*b_j into accumulator bits [11(i+j)+20 : 11(i+j)].
REQ-015 j SHALL increment every MUL cycle; at j=14 it SHALL wrap to 0 and i SHALL increment; after the product (i=14, j=14) the FSM SHALL enter RED.
REQ-016 MUL SHALL last exactly 225 cycles when GF163_ZSKIP_EN is undefined.
REQ-017 RED SHALL reduce the accumulator modulo f(x) in one cycle, fully, with two folds so that degree <= 162; the result SHALL be registered into c, and the FSM SHALL enter DONE.
REQ-018 In DONE, done SHALL be 1 and busy 0 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-019 busy SHALL be 1 in MUL and RED only.
REQ-020 With the start edge at edge k, done SHALL be high in the cycle following edge k+226 when GF163_ZSKIP_EN is undefined.
REQ-021 start SHALL be ignored in MUL, RED and DONE; operand changes after capture SHALL NOT affect the result.
REQ-022 c SHALL hold its last value until the next RED completes; it SHALL NOT change in IDLE, MUL or DONE.
REQ-023 A start asserted in the cycle immediately after DONE (IDLE) SHALL be accepted; back-to-back operations SHALL cost 228 cycles each.

Reset
REQ-024 Asserting rst SHALL immediately set the state to IDLE, busy=0, done=0, c=0, i=j=0, and clear the accumulator, including during MUL or RED.
REQ-025 An operation interrupted by rst SHALL be discarded with no done pulse; the first start after rst deasserts SHALL complete normally.

Configuration
REQ-026 Macro GF163_ZSKIP_EN SHALL compile in zero-digit skipping; when undefined, the schedule SHALL be the fixed 225-cycle schedule.
REQ-027 With GF163_ZSKIP_EN defined, in MUL at j=0, if a_i == 0 the block SHALL spend one cycle on that row and advance directly to i+1, j=0 (or to RED if i=14); a nonzero row SHALL take 15 cycles.
REQ-028 With GF163_ZSKIP_EN defined, MUL length SHALL be 15*N + (15-N) cycles, where N is the number of nonzero A digits, and the result SHALL be identical to the undefined case.

Verification
REQ-029 a=1, b=1, start pulse -> c=163'h1, done high exactly 226 cycles after the start edge (macro off), busy high for 226 cycles.
REQ-030 a=1<<162, b=1<<1 -> c=163'hC9 (x^7+x^6+x^3+1); a=b=all-ones -> c matches the bit-serial golden model.
REQ-031 start re-pulsed with new operands at cycle 50 of an operation -> ignored; c equals the product of the first operands; exactly one done pulse.
REQ-032 rst asserted at MUL cycle 100 -> busy, done and c all 0 within the same cycle; next start with a=3, b=5 -> c=163'hF.
REQ-033 start held high continuously for 3 operations -> 3 done pulses spaced 228 cycles apart, each with correct c.
REQ-034 GF163_ZSKIP_EN defined, a=1, b=1<<100 -> MUL lasts 29 cycles, done at edge k+30, c=1<<100; with a=0 -> 15 MUL cycles, c=0.
